// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake of the configurable UART transmitter.
interface uart_tx_cfg_if #(
    parameter int data_bits_p = 8
);
    logic                   v_i;
    logic [data_bits_p-1:0] data_i;
    logic                   ready_o;

    modport master (output v_i, output data_i, input ready_o);
    modport slave  (input v_i, input data_i, output ready_o);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: small write FIFO feeding a start/data/parity/stop
// framer with a registered serial output.
module uart_tx_cfg #(
    parameter int clk_per_bit_p = 10416,
    parameter int data_bits_p   = 8,
    parameter int parity_p      = 0,
    parameter int stop_bits_p   = 1,
    parameter int fifo_els_p    = 4
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    uart_tx_cfg_if.slave  in_if,
    output logic          tx_o,
    output logic          busy_o,
    output logic          done_o
);

    if (clk_per_bit_p < 2) begin : g_bad_clk_per_bit
        $error("uart_tx_cfg: clk_per_bit_p must be >= 2");
    end
    if (data_bits_p < 5 || data_bits_p > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: data_bits_p must be 5..9");
    end
    if (parity_p < 0 || parity_p > 2) begin : g_bad_parity
        $error("uart_tx_cfg: parity_p must be 0, 1 or 2");
    end
    if (stop_bits_p < 1 || stop_bits_p > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: stop_bits_p must be 1 or 2");
    end
    if (fifo_els_p < 2 || (fifo_els_p & (fifo_els_p - 1)) != 0) begin : g_bad_fifo_els
        $error("uart_tx_cfg: fifo_els_p must be a power of 2, >= 2");
    end

    localparam int cnt_w_lp = $clog2(clk_per_bit_p);
    localparam int idx_w_lp = $clog2(data_bits_p);
    localparam int aw_lp    = $clog2(fifo_els_p);

    localparam logic [cnt_w_lp-1:0] cnt_last_lp  = cnt_w_lp'(clk_per_bit_p - 1);
    localparam logic [idx_w_lp-1:0] data_last_lp = idx_w_lp'(data_bits_p - 1);
    localparam logic [idx_w_lp-1:0] stop_last_lp = idx_w_lp'(stop_bits_p - 1);
    localparam logic [aw_lp:0]      fifo_full_lp = (aw_lp + 1)'(fifo_els_p);

    typedef enum logic [2:0] {
        e_idle,
        e_start,
        e_data,
        e_parity,
        e_stop
    } state_e;

    // ---------------- transmit FIFO ----------------
    logic [data_bits_p-1:0] mem_q [fifo_els_p];
    logic [aw_lp-1:0]       wr_ptr_q, rd_ptr_q;
    logic [aw_lp:0]         count_q;
    logic                   push, pop, fifo_empty;
    logic [data_bits_p-1:0] head;

    assign in_if.ready_o = (count_q != fifo_full_lp);
    assign push          = in_if.v_i & in_if.ready_o;
    assign fifo_empty    = (count_q == '0);
    assign head          = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; emptiness is defined by the pointers and count alone.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_if.data_i;
    end

    // ---------------- framer ----------------
    state_e                 state_q, state_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic [idx_w_lp-1:0]    idx_q, idx_d;
    logic [data_bits_p-1:0] shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   bit_end, start_frame;

    assign bit_end = (cnt_q == cnt_last_lp);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        start_frame = 1'b0;

        if (state_q != e_idle) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            e_idle: begin
                tx_d        = 1'b1;
                start_frame = !fifo_empty;
            end
            e_start: begin
                if (bit_end) begin
                    state_d = e_data;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            e_data: begin
                if (bit_end) begin
                    if (idx_q == data_last_lp) begin
                        idx_d = '0;
                        if (parity_p != 0) begin
                            state_d = e_parity;
                            tx_d    = par_q;
                        end else begin
                            state_d = e_stop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            e_parity: begin
                if (bit_end) begin
                    state_d = e_stop;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            e_stop: begin
                if (bit_end) begin
                    if (idx_q == stop_last_lp) begin
                        idx_d       = '0;
                        done_d      = 1'b1;
                        state_d     = e_idle;
                        tx_d        = 1'b1;
                        start_frame = !fifo_empty;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = e_idle;
        endcase

        // Loading happens only from idle or at the very end of a stop bit, so
        // FIFO traffic can never disturb the frame on the line.
        if (start_frame) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = (^head) ^ (parity_p == 2);
            tx_d    = 1'b0;
            cnt_d   = '0;
            state_d = e_start;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx_o   = tx_q;
    assign done_o = done_q;
    assign busy_o = (state_q != e_idle) || !fifo_empty;

endmodule
